// File: rtl/half_adder_checker.sv
// Response checker for a half adder: scores {a, b, sum, carry} observation vectors,
// counts mismatches, captures the first failing vector and gives a verdict per run.
module half_adder_checker #(
    parameter int CNT_W       = 8,
    parameter int NUM_VECTORS = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [3:0]       first_err_vec
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state;
    logic             mismatch;
    logic [CNT_W-1:0] err_next;

    always_comb begin
        mismatch = (sum != (a ^ b)) || (carry != (a & b));
        err_next = err_count;
        if (mismatch && err_count != CNT_MAX)
            err_next = err_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_pulse     <= 1'b0;
            vec_count     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_vec <= '0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // Start from either idle state clears the statistics of the previous run.
                    if (start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        vec_count     <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        first_err_vec <= '0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        vec_count <= vec_count + 1'b1;
                        err_count <= err_next;
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                            // err_count only leaves zero on the first mismatch of a run.
                            if (err_count == '0) begin
                                first_err_idx <= vec_count;
                                first_err_vec <= {a, b, sum, carry};
                            end
                        end
                        if (vec_count == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
